// File: rtl/segment_scan.sv
// Time-multiplexed driver for NUM_DIGITS hex 7-segment digits on a shared segment bus,
// with blanking, leading-zero suppression, PWM brightness, blink and frame-synchronous loading.
module segment_scan #(
   parameter int NUM_DIGITS   = 8,
   parameter int PRESCALE     = 8,
   parameter int BRIGHT_W     = 3,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   nums,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic [NUM_DIGITS-1:0]     blank,
   input  logic                      lz_en,
   input  logic [BRIGHT_W-1:0]       brightness,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   output logic [NUM_DIGITS-1:0]     DIG,
   output logic [7:0]                Y,
   output logic                      frame_done,
   output logic                      pending
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int MW = PW + BRIGHT_W + 2;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'h0: seg_decode = 7'h3F;
         4'h1: seg_decode = 7'h06;
         4'h2: seg_decode = 7'h5B;
         4'h3: seg_decode = 7'h4F;
         4'h4: seg_decode = 7'h66;
         4'h5: seg_decode = 7'h6D;
         4'h6: seg_decode = 7'h7D;
         4'h7: seg_decode = 7'h07;
         4'h8: seg_decode = 7'h7F;
         4'h9: seg_decode = 7'h6F;
         4'hA: seg_decode = 7'h77;
         4'hB: seg_decode = 7'h7C;
         4'hC: seg_decode = 7'h39;
         4'hD: seg_decode = 7'h5E;
         4'hE: seg_decode = 7'h79;
         4'hF: seg_decode = 7'h71;
      endcase
   endfunction

   logic [PW-1:0]           pre_cnt_q, pre_cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
   logic                    blink_q, blink_d;
   logic                    pending_q, pending_d;
   logic [4*NUM_DIGITS-1:0] pend_nums_q, pend_nums_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic [4*NUM_DIGITS-1:0] sh_nums_q, sh_nums_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
   logic [NUM_DIGITS-1:0]   dig_q, dig_d;
   logic [7:0]              y_q, y_d;
   logic                    frame_done_q, frame_done_d;

   logic                    slot_tick;
   logic                    boundary;
   logic                    all_zero;
   logic [NUM_DIGITS-1:0]   lz_dark;
   logic [3:0]              cur_val;
   logic [MW-1:0]           pwm_lhs, pwm_rhs;
   logic                    pwm_on;
   logic                    dark;

   always_comb begin
      slot_tick   = (pre_cnt_q == PRE_LAST);
      boundary    = slot_tick && (idx_q == IDX_LAST);
      pre_cnt_d   = slot_tick ? '0 : pre_cnt_q + 1'b1;
      idx_d       = idx_q;
      frame_cnt_d = frame_cnt_q;
      blink_d     = blink_q;
      if (slot_tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      if (boundary) begin
         if (frame_cnt_q == FRM_LAST) begin
            frame_cnt_d = '0;
            blink_d     = ~blink_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
      frame_done_d = boundary;
   end

   // Shadow only changes on the frame boundary, so a frame always shows one coherent data set;
   // a load on the boundary itself bypasses the pending buffer.
   always_comb begin
      pending_d    = pending_q;
      pend_nums_d  = pend_nums_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      sh_nums_d    = sh_nums_q;
      sh_dp_d      = sh_dp_q;
      sh_blank_d   = sh_blank_q;
      if (boundary) begin
         if (load) begin
            sh_nums_d  = nums;
            sh_dp_d    = dp;
            sh_blank_d = blank;
         end else if (pending_q) begin
            sh_nums_d  = pend_nums_q;
            sh_dp_d    = pend_dp_q;
            sh_blank_d = pend_blank_q;
         end
         pending_d = 1'b0;
      end else if (load) begin
         pend_nums_d  = nums;
         pend_dp_d    = dp;
         pend_blank_d = blank;
         pending_d    = 1'b1;
      end
   end

   always_comb begin
      lz_dark  = '0;
      all_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         all_zero   = all_zero & (sh_nums_q[4*k +: 4] == 4'h0);
         lz_dark[k] = all_zero;
      end
   end

   // PWM compare widened so pre_cnt*2^BRIGHT_W and (brightness+1)*PRESCALE never truncate.
   always_comb begin
      cur_val = sh_nums_q[{idx_q, 2'b00} +: 4];
      pwm_lhs = MW'(pre_cnt_q) << BRIGHT_W;
      pwm_rhs = (MW'(brightness) + MW'(1)) * MW'(PRESCALE);
      pwm_on  = (pwm_lhs < pwm_rhs);
      dark    = sh_blank_q[idx_q] | (blink_q & blink_mask[idx_q]) | (lz_en & lz_dark[idx_q]);
      dig_d   = '1;
      y_d     = '0;
      if (pwm_on && !dark) begin
         dig_d = ~(NUM_DIGITS'(1) << idx_q);
         y_d   = {sh_dp_q[idx_q], seg_decode(cur_val)};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_cnt_q    <= '0;
         idx_q        <= '0;
         frame_cnt_q  <= '0;
         blink_q      <= 1'b0;
         pending_q    <= 1'b0;
         sh_nums_q    <= '0;
         sh_dp_q      <= '0;
         sh_blank_q   <= '1;
         dig_q        <= '1;
         y_q          <= '0;
         frame_done_q <= 1'b0;
      end else begin
         pre_cnt_q    <= pre_cnt_d;
         idx_q        <= idx_d;
         frame_cnt_q  <= frame_cnt_d;
         blink_q      <= blink_d;
         pending_q    <= pending_d;
         sh_nums_q    <= sh_nums_d;
         sh_dp_q      <= sh_dp_d;
         sh_blank_q   <= sh_blank_d;
         dig_q        <= dig_d;
         y_q          <= y_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Pending data is only meaningful while pending_q is set, so it needs no reset.
   always_ff @(posedge clk) begin
      pend_nums_q  <= pend_nums_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
   end

   assign DIG        = dig_q;
   assign Y          = y_q;
   assign frame_done = frame_done_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_segment_scan.sv
// Directed bench for segment_scan (4 digits, prescale 8) with a time-based reference model.
module tb_segment_scan;

   localparam int N  = 4;
   localparam int P  = 8;
   localparam int BW = 3;
   localparam int BF = 2;
   localparam logic [7:0] SEG7 [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load;
   logic [15:0]   nums;
   logic [3:0]    dp;
   logic [3:0]    blank;
   logic          lz_en;
   logic [BW-1:0] brightness;
   logic [3:0]    blink_mask;
   logic [3:0]    DIG;
   logic [7:0]    Y;
   logic          frame_done;
   logic          pending;

   int checks = 0;
   int errors = 0;

   segment_scan #(.NUM_DIGITS(N), .PRESCALE(P), .BRIGHT_W(BW), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst(rst), .load(load), .nums(nums), .dp(dp), .blank(blank),
      .lz_en(lz_en), .brightness(brightness), .blink_mask(blink_mask),
      .DIG(DIG), .Y(Y), .frame_done(frame_done), .pending(pending)
   );

   always #5 clk = ~clk;

   // Reference: everything derives from m_cnt, the number of clock edges since reset release.
   int          m_cnt;
   logic [15:0] m_sh_nums, m_buf_nums;
   logic [3:0]  m_sh_dp, m_sh_blank, m_buf_dp, m_buf_blank;
   logic        m_pend;
   logic [3:0]  exp_dig;
   logic [7:0]  exp_y;
   logic        exp_fd, exp_pend;

   always @(posedge clk or negedge rst) begin : model
      int pre, idx, frame;
      logic bnd, on, dark, np;
      logic [3:0] v;
      if (!rst) begin
         m_cnt      <= 0;
         m_sh_nums  <= '0;
         m_sh_dp    <= '0;
         m_sh_blank <= '1;
         m_pend     <= 1'b0;
         exp_dig    <= 4'hF;
         exp_y      <= 8'h00;
         exp_fd     <= 1'b0;
         exp_pend   <= 1'b0;
      end else begin
         pre   = m_cnt % P;
         idx   = (m_cnt / P) % N;
         frame = m_cnt / (P * N);
         bnd   = ((m_cnt % (P * N)) == P * N - 1);
         on    = (pre * (1 << BW)) < ((int'(brightness) + 1) * P);
         v     = 4'((m_sh_nums >> (4 * idx)) & 16'hF);
         dark  = m_sh_blank[idx] || (((frame / BF) % 2 == 1) && blink_mask[idx]) ||
                 (lz_en && idx != 0 && ((m_sh_nums >> (4 * idx)) == 16'h0));
         if (on && !dark) begin
            exp_dig <= ~(4'b0001 << idx);
            exp_y   <= SEG7[v] | {m_sh_dp[idx], 7'h00};
         end else begin
            exp_dig <= 4'hF;
            exp_y   <= 8'h00;
         end
         exp_fd <= bnd;
         np = m_pend;
         if (load && bnd) begin
            m_sh_nums <= nums; m_sh_dp <= dp; m_sh_blank <= blank; np = 1'b0;
         end else if (load) begin
            m_buf_nums <= nums; m_buf_dp <= dp; m_buf_blank <= blank; np = 1'b1;
         end else if (bnd && m_pend) begin
            m_sh_nums <= m_buf_nums; m_sh_dp <= m_buf_dp; m_sh_blank <= m_buf_blank; np = 1'b0;
         end
         m_pend   <= np;
         exp_pend <= np;
         m_cnt    <= m_cnt + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t cnt=%0d)", nm, act, req, $time, m_cnt);
      end
   endtask

   always @(negedge clk) begin : compare
      chk("dig", 32'(DIG), 32'(exp_dig));
      chk("y", 32'(Y), 32'(exp_y));
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      chk("pending", 32'(pending), 32'(exp_pend));
   end

   task automatic lit(input string nm, input logic [3:0] d, input logic [7:0] y);
      chk({nm, "_dig"}, 32'(DIG), 32'(d));
      chk({nm, "_y"}, 32'(Y), 32'(y));
      chk({nm, "_model_dig"}, 32'(exp_dig), 32'(d));
      chk({nm, "_model_y"}, 32'(exp_y), 32'(y));
   endtask

   task automatic wait_cnt(input int n);
      int g = 0;
      while (m_cnt != n && g < 5000) begin
         @(negedge clk);
         g++;
      end
      if (m_cnt != n) begin
         checks++;
         errors++;
         $display("FAIL wait_cnt actual=%0d required=%0d", m_cnt, n);
      end
   endtask

   task automatic strobe_load(input logic [15:0] n);
      nums = n;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      int nfd, nlit;
      load = 0; nums = 0; dp = 0; blank = 0; lz_en = 0; brightness = 3'd7; blink_mask = 0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Reset mid-slot with a load pending
      @(negedge clk);
      strobe_load(16'h9999);
      chk("pend_before_reset", 32'(pending), 32'd1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_dig", 32'(DIG), 32'hF);
      chk("async_rst_y", 32'(Y), 32'h0);
      chk("async_rst_pend", 32'(pending), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      nfd = 0; nlit = 0;
      for (int i = 0; i < 96; i++) begin
         @(negedge clk);
         if (frame_done) nfd++;
         if (DIG != 4'hF) nlit++;
         if (i == 31) chk("fd_first", 32'(frame_done), 32'd1);
      end
      chk("fd_count_3frames", 32'(nfd), 32'd3);
      chk("dark_3frames", 32'(nlit), 32'd0);

      // Load and decode
      dp = 4'b0010;
      strobe_load(16'h12AF);
      chk("pend_after_load", 32'(pending), 32'd1);
      wait_cnt(128);
      chk("pend_committed", 32'(pending), 32'd0);
      chk("fd_commit", 32'(frame_done), 32'd1);
      wait_cnt(129); lit("dec_d0", 4'b1110, 8'h71);
      wait_cnt(137); lit("dec_d1", 4'b1101, 8'hF7);
      wait_cnt(145); lit("dec_d2", 4'b1011, 8'h5B);
      wait_cnt(153); lit("dec_d3", 4'b0111, 8'h06);

      // Brightness
      wait_cnt(160); brightness = 3'd3;
      wait_cnt(161); lit("br3_on0", 4'b1110, 8'h71);
      wait_cnt(164); lit("br3_on3", 4'b1110, 8'h71);
      wait_cnt(165); lit("br3_off4", 4'hF, 8'h00);
      wait_cnt(192); brightness = 3'd0;
      wait_cnt(193); lit("br0_on0", 4'b1110, 8'h71);
      wait_cnt(194); lit("br0_off1", 4'hF, 8'h00);

      // Leading-zero suppression
      wait_cnt(224);
      brightness = 3'd7; lz_en = 1'b1; dp = 4'b0000;
      strobe_load(16'h0050);
      wait_cnt(257); lit("lz_d0", 4'b1110, 8'h3F);
      wait_cnt(265); lit("lz_d1", 4'b1101, 8'h6D);
      wait_cnt(273); lit("lz_d2", 4'hF, 8'h00);
      wait_cnt(281); lit("lz_d3", 4'hF, 8'h00);
      wait_cnt(288);
      strobe_load(16'h0000);
      wait_cnt(321); lit("lz0_d0", 4'b1110, 8'h3F);
      wait_cnt(329); lit("lz0_d1", 4'hF, 8'h00);
      wait_cnt(337); lit("lz0_d2", 4'hF, 8'h00);

      // Double buffering: last load wins, then load on the boundary
      wait_cnt(352);
      lz_en = 1'b0;
      strobe_load(16'h1111);
      chk("db_pend1", 32'(pending), 32'd1);
      wait_cnt(360);
      strobe_load(16'h2222);
      wait_cnt(380);
      chk("db_pend_hold", 32'(pending), 32'd1);
      lit("db_old_frame", 4'b0111, 8'h3F);
      wait_cnt(384); chk("db_pend_clr", 32'(pending), 32'd0);
      wait_cnt(385); lit("db_d0", 4'b1110, 8'h5B);
      wait_cnt(409); lit("db_d3", 4'b0111, 8'h5B);
      wait_cnt(415);
      lit("coin_before", 4'b0111, 8'h5B);
      strobe_load(16'h1234);
      chk("coin_pend", 32'(pending), 32'd0);
      chk("coin_fd", 32'(frame_done), 32'd1);
      wait_cnt(417); lit("coin_d0", 4'b1110, 8'h66);
      wait_cnt(441); lit("coin_d3", 4'b0111, 8'h06);

      // Blink on digit 0 only
      wait_cnt(448); blink_mask = 4'b0001;
      wait_cnt(449); lit("blink_f14_d0", 4'hF, 8'h00);
      wait_cnt(457); lit("blink_f14_d1", 4'b1101, 8'h4F);
      wait_cnt(513); lit("blink_f16_d0", 4'b1110, 8'h66);
      wait_cnt(577); lit("blink_f18_d0", 4'hF, 8'h00);
      wait_cnt(641); lit("blink_f20_d0", 4'b1110, 8'h66);

      // Reset while a digit is lit
      wait_cnt(650); lit("pre_reset_lit", 4'b1101, 8'h4F);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_lit_dig", 32'(DIG), 32'hF);
      chk("rst_lit_y", 32'(Y), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/segment_scan.md
Name: segment_scan

Overview:
- Parametrised successor to the two-digit scanned display driver.
- Drives NUM_DIGITS time-multiplexed 7-segment digits with a shared segment bus.
- Adds hex decode, per-digit decimal point, blanking, leading-zero suppression, PWM brightness, blink and frame-synchronous double-buffered loading.
- Sits between game/score logic and the board display pins.

Parameters:
- NUM_DIGITS, 8, number of scanned digits (2..8).
- PRESCALE, 8, clk cycles per digit slot (>=1).
- BRIGHT_W, 3, width of the brightness control.
- BLINK_FRAMES, 64, frames per blink phase (>=1).

Ports:
- clk  in  1  scan clock, 1 kHz nominal.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle strobe; captures nums/dp/blank into the pending buffer.
- nums  in  4*NUM_DIGITS  hex value per digit; digit k is bits [4k+3:4k]; digit 0 is rightmost.
- dp  in  NUM_DIGITS  decimal point enable per digit.
- blank  in  NUM_DIGITS  force digit dark.
- lz_en  in  1  leading-zero suppression enable (live input).
- brightness  in  BRIGHT_W  duty control; all-ones means 100 %.
- blink_mask  in  NUM_DIGITS  digits that blink (live input).
- DIG  out  NUM_DIGITS  digit select, active-low; bit k drives digit k.
- Y  out  8  segments {dp,g,f,e,d,c,b,a}, active-high.
- frame_done  out  1  one-cycle pulse at each frame boundary.
- pending  out  1  a load is waiting for commit.

Behaviour:
- One clock domain; reset is asynchronous, active-low.
- Reset values:
  - DIG all ones; Y = 0; frame_done = 0; pending = 0.
  - Prescaler, digit index, frame counter and blink phase = 0; blink phase 0 = visible.
  - Shadow nums and dp = 0; shadow blank all ones, so the display stays dark until the first commit.
- Reset asserted mid-operation forces the outputs above immediately and discards any pending load.
- Prescaler pre_cnt runs 0..PRESCALE-1 and wraps. slot_tick = (pre_cnt == PRESCALE-1).
- Digit index idx advances on slot_tick and wraps from NUM_DIGITS-1 to 0.
- Frame boundary = slot_tick with idx == NUM_DIGITS-1.
  - frame_done is registered and high for exactly the cycle after that edge.
- Loading:
  - load copies nums/dp/blank into the pending buffer and sets pending.
  - A later load before commit overwrites the buffer; last load wins.
  - At the frame boundary, if pending = 1: pending buffer goes to shadow and pending clears.
  - load coincident with the boundary writes the input data straight to shadow; pending ends 0.
  - A committed frame is never torn: digit 0 of the next frame uses the new data.
- Blink: frame counter counts 0..BLINK_FRAMES-1 and wraps on frame boundaries; blink phase toggles on each wrap.
- Digit k is dark if any of the following holds:
  - shadow blank[k];
  - blink phase = 1 and blink_mask[k];
  - lz_en = 1, k != 0, and shadow digits k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never zero-suppressed.
- PWM on-condition: pre_cnt * 2^BRIGHT_W < (brightness+1) * PRESCALE, using full-width unsigned arithmetic with no truncation.
- Output stage (registered; one clk latency from the current pre_cnt/idx):
  - If on and the current digit is not dark: DIG = ~(1<<idx); Y = {dp, decode(value)}.
  - Otherwise: DIG all ones, Y = 0. Y is never driven while all digits are off.
- Decode, 0..F in hex (bit 7 = dp):
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.

Test Plan:
Bench configuration: NUM_DIGITS=4, PRESCALE=8, BRIGHT_W=3, BLINK_FRAMES=2.
1. Reset: hold rst low mid-slot with load pending → DIG=4'hF, Y=0, pending=0 immediately. After release with no load, DIG stays 4'hF for 3 frames; frame_done pulses every 32 cycles.
2. Load and decode: load nums=16'h12AF, dp=4'b0010, blank=0, brightness=7, lz_en=0 → after the next boundary, per slot for 8 cycles each:
   - DIG=1110, Y=71;
   - DIG=1101, Y=F7;
   - DIG=1011, Y=5B;
   - DIG=0111, Y=06.
3. Brightness: brightness=3 → each slot has DIG low for pre_cnt 0..3 (4 cycles, shifted by 1 clk), then DIG=4'hF and Y=0 for 4 cycles. brightness=0 → 1 cycle on per slot.
4. Leading zeros: lz_en=1, nums=16'h0050 → digits 3 and 2 dark, digit 1 Y=6D, digit 0 Y=3F. nums=16'h0000 → only digit 0 lit, Y=3F.
5. Double buffering:
   - load 16'h1111 then 16'h2222 in the same frame → only 2222 is displayed; pending=1 until the boundary.
   - load coincident with the boundary → committed at that boundary; pending stays 0.
6. Blink: blink_mask=4'b0001 → digit 0 lit in frames 0-1, dark in frames 2-3, lit in frames 4-5; other digits unaffected.
